// File: rtl/boot_loader.sv
// boot_loader: receives a byte stream (count, big-endian 16-bit words,
// XOR checksum), writes each word to main memory from address 0 upward and
// holds the processor in reset until the image is loaded and verified.
//
// Handshake: a byte moves on a rising edge where rx_valid && rx_ready.
// rx_ready depends on the state only, never on rx_valid.
module boot_loader #(
    parameter int data_width = 16,
    parameter int addr_width = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [addr_width-1:0] mem_addr,
    output logic [data_width-1:0] mem_wdata,
    output logic                  mem_wr,
    output logic                  cpu_rst,
    output logic                  load_done,
    output logic                  load_err
);

    localparam logic [2:0] S_COUNT = 3'd0;
    localparam logic [2:0] S_HI    = 3'd1;
    localparam logic [2:0] S_LO    = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_CHK   = 3'd4;
    localparam logic [2:0] S_RUN   = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    // A count byte of zero means a full memory image (2^addr_width words).
    localparam logic [addr_width:0] full_count = {1'b1, {addr_width{1'b0}}};
    localparam logic [addr_width:0] one        = {{addr_width{1'b0}}, 1'b1};

    logic [2:0]            state;
    logic [addr_width:0]   count_n;   // one bit wider so 2^addr_width fits
    logic [addr_width:0]   word_idx;
    logic [7:0]            xor_acc;
    logic [7:0]            hi_byte;
    logic [addr_width-1:0] addr_q;    // holds the last written address
    logic [data_width-1:0] wdata_q;   // holds the last written word
    logic                  accept;

    assign accept = rx_valid && rx_ready;

    // Byte acceptance is allowed only in the states that wait for input.
    always_comb begin
        rx_ready = 1'b0;
        case (state)
            S_COUNT, S_HI, S_LO, S_CHK: rx_ready = 1'b1;
            default:                    rx_ready = 1'b0;
        endcase
    end

    // Loader FSM plus the word assembly, checksum and address registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_COUNT;
            count_n  <= '0;
            word_idx <= '0;
            xor_acc  <= '0;
            hi_byte  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            case (state)
                S_COUNT: if (accept) begin
                    count_n  <= (rx_data == 8'h00) ? full_count
                                                   : {1'b0, rx_data[addr_width-1:0]};
                    xor_acc  <= rx_data;
                    word_idx <= '0;
                    state    <= S_HI;
                end
                S_HI: if (accept) begin
                    hi_byte <= rx_data;
                    xor_acc <= xor_acc ^ rx_data;
                    state   <= S_LO;
                end
                S_LO: if (accept) begin
                    xor_acc <= xor_acc ^ rx_data;
                    // Address/data are captured here so they stay stable
                    // after the write until the next word replaces them.
                    addr_q  <= word_idx[addr_width-1:0];
                    wdata_q <= {hi_byte, rx_data};
                    state   <= S_WRITE;
                end
                S_WRITE: begin
                    if (word_idx == count_n - one) begin
                        state <= S_CHK;
                    end else begin
                        word_idx <= word_idx + one;
                        state    <= S_HI;
                    end
                end
                S_CHK: if (accept) begin
                    state <= (rx_data == xor_acc) ? S_RUN : S_ERR;
                end
                S_RUN:   state <= S_RUN;
                S_ERR:   state <= S_ERR;
                default: state <= S_COUNT;
            endcase
        end
    end

    // Status and memory port decode. The write strobe is suppressed while rst
    // is high so a reset landing on S_WRITE aborts that write.
    always_comb begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_wr    = (state == S_WRITE) && !rst;
        cpu_rst   = (state != S_RUN);
        load_done = (state == S_RUN);
        load_err  = (state == S_ERR);
    end

endmodule
